agc_scaler: RTL and testbench
=============================

Name: agc_scaler

Overview:
- Downstream neighbour of the a2_timer stage. Consumes the timer's F01A/F01B phase strobes and extends FS01 into a binary scaler chain FS02..FS(NSTAGES).
- Each stage also gets per-stage rise/fall strobes FnnA/FnnB, used as slow timing sources for counters, alarms and I/O downstream.
- Compiles in an optional scaler-fail alarm that flags loss of timer strobes.

Parameters:
- NSTAGES, 32: highest scaler stage index. Stages are FS02..FS(NSTAGES), so W = NSTAGES-1 bits. Legal range 3..33.
- ALARM_TIMEOUT, 4096: SIM_CLK cycles without an F01B strobe before SCAFAL asserts. Only meaningful with the optional feature.

Ports:
- SIM_CLK  in  1  single system clock; all state updates on its rising edge.
- SIM_RST  in  1  asynchronous, active-high reset.
- F01A  in  1  one-SIM_CLK-wide strobe from the timer on FS01 rise.
- F01B  in  1  one-SIM_CLK-wide strobe from the timer on FS01 fall; this is the increment source.
- SCLCLR  in  1  synchronous clear of all scaler stages.
- FS  out  W  stage levels; FS[i] is FS(i+2).
- FA  out  W  rise strobes; FA[i] is F(i+2)A, one cycle wide.
- FB  out  W  fall strobes; FB[i] is F(i+2)B, one cycle wide.
- SCAFAL  out  1  scaler-fail alarm; tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, SIM_RST=1): FS=0, FA=0, FB=0, SCAFAL=0, internal watchdog count=0. All outputs are registered.
- Increment: on a cycle with F01B=1 and SCLCLR=0, FS <= FS+1, modulo 2^W.
- Strobes:
  - Registered in the same edge as the FS update, so they are visible together with the new FS value, one cycle after F01B.
  - FA[i]=1 exactly when FS[i] goes 0->1 on that edge.
  - FB[i]=1 exactly when FS[i] goes 1->0 on that edge.
  - All strobe bits return to 0 on the next edge unless another increment occurs.
- F01A does not change FS. It is accepted for interface completeness and watchdog qualification only.
- Wrap-around: all-ones -> all-zeros. Every FB[i]=1 in the same cycle; FA=0.
- Carry ripple is single-cycle. There are no intermediate states; FS always changes atomically.
- SCLCLR=1: FS <= 0, FA <= 0, FB <= 0 on that edge, with no strobes generated for the stages that fall. The watchdog is not affected by SCLCLR.
- Simultaneous events:
  - SCLCLR together with F01B: clear wins and the increment is dropped.
  - F01A together with F01B (protocol violation): treated as F01B only.
- Back-to-back F01B on consecutive cycles: each is counted, and strobes update every cycle.
- SIM_RST mid-operation: immediate return to the reset values. Counting resumes on the first F01B after release.

Optional Feature:
- Macro AGC_SCALER_ALARM_EN.
- Defined:
  - A watchdog counter increments each SIM_CLK and zeroes on every cycle with F01B=1.
  - When the count reaches ALARM_TIMEOUT, SCAFAL <= 1 and the counter saturates.
  - SCAFAL is held until the edge after the next F01B, where it drops to 0.
- Undefined: no watchdog logic; SCAFAL is constant 0.

Test Plan (NSTAGES=6, W=5, ALARM_TIMEOUT=16 unless stated):
- Reset then three F01B pulses spaced 4 cycles apart -> FS=1,2,3, each visible one cycle after its pulse. Strobes per pulse:
  - 1st: FA[0]=1.
  - 2nd: FB[0]=1 and FA[1]=1.
  - 3rd: FA[0]=1.
  - Every strobe is exactly 1 cycle wide.
- 32 F01B pulses from reset -> FS returns to 0. On the 32nd: FB=5'b11111, FA=0. Over the run, FA[4] fires once, after the 16th pulse.
- FS=5, then SCLCLR and F01B in the same cycle -> FS=0, FA=FB=0. The next F01B gives FS=1.
- F01B on 5 consecutive cycles -> FS steps 1..5 on consecutive cycles, with FA[0]/FB[0] alternating every cycle.
- SIM_RST asserted asynchronously between clock edges with FS=9 -> all outputs are 0 before the next edge. After release, FS stays 0 until an F01B.
- With AGC_SCALER_ALARM_EN: no F01B for 16 cycles -> SCAFAL=1. It stays 1 until the edge after the next F01B, then 0.
- Without AGC_SCALER_ALARM_EN: the same stimulus leaves SCAFAL=0.

Source files
------------

// File: rtl/agc_scaler.sv
// agc_scaler: binary scaler chain FS02..FS(NSTAGES) with per-stage rise/fall strobes.
// Define AGC_SCALER_ALARM_EN to compile in the SCAFAL watchdog on missing F01B strobes.
module agc_scaler #(
  parameter int NSTAGES = 32,
  parameter int ALARM_TIMEOUT = 4096,
  localparam int W = NSTAGES - 1
) (
  input  logic         SIM_CLK,
  input  logic         SIM_RST,
  input  logic         F01A,
  input  logic         F01B,
  input  logic         SCLCLR,
  output logic [W-1:0] FS,
  output logic [W-1:0] FA,
  output logic [W-1:0] FB,
  output logic         SCAFAL
);
  logic [W-1:0] nxt;
  logic unused_f01a;
  assign nxt = FS + W'(1);
  assign unused_f01a = F01A;
  // Strobes come from comparing old and new levels, so a wrap drops every stage at once.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST || SCLCLR) begin
      FS <= '0;
      FA <= '0;
      FB <= '0;
    end else begin
      FS <= F01B ? nxt : FS;
      FA <= F01B ? nxt & ~FS : '0;
      FB <= F01B ? FS & ~nxt : '0;
    end
  end
`ifdef AGC_SCALER_ALARM_EN
  localparam int CW = $clog2(ALARM_TIMEOUT + 1);
  logic [CW-1:0] wd, wd_nxt;
  // Saturating at the timeout keeps the alarm latched until the next F01B.
  always_comb wd_nxt = F01B ? '0 : (wd == CW'(ALARM_TIMEOUT)) ? wd : wd + CW'(1);
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      wd <= '0;
      SCAFAL <= 1'b0;
    end else begin
      wd <= wd_nxt;
      SCAFAL <= wd_nxt == CW'(ALARM_TIMEOUT);
    end
  end
`else
  assign SCAFAL = 1'b0;
`endif
endmodule

// File: tb/tb_agc_scaler.sv
// tb_agc_scaler: directed stimulus with a counting model and per-cycle compare against agc_scaler.
module tb_agc_scaler;
  localparam int NST = 6;
  localparam int W = NST - 1;
  localparam int TMO = 16;
  localparam int MODV = 1 << W;
  logic clk = 0, rst = 0, f01a = 0, f01b = 0, sclclr = 0;
  logic [W-1:0] fs, fa, fb;
  logic scafal;
  int errors = 0, checks = 0;
  int m_cnt = 0, idle = 0;
  logic [W-1:0] m_fa = '0, m_fb = '0;
  logic m_sf = 0;
  int fa4_hits, fa4_at;
`ifdef AGC_SCALER_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  agc_scaler #(.NSTAGES(NST), .ALARM_TIMEOUT(TMO)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .F01A(f01a), .F01B(f01b), .SCLCLR(sclclr),
    .FS(fs), .FA(fa), .FB(fb), .SCAFAL(scafal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an integer count; strobes are the bits that rose/fell between old and new count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_fa = '0; m_fb = '0; idle = 0; m_sf = 0;
    end else begin
      int n;
      n = m_cnt;
      if (sclclr) n = 0;
      else if (f01b) n = (m_cnt + 1) % MODV;
      for (int i = 0; i < W; i++) begin
        m_fa[i] = !sclclr && f01b && !((m_cnt >> i) & 1) && ((n >> i) & 1);
        m_fb[i] = !sclclr && f01b && ((m_cnt >> i) & 1) && !((n >> i) & 1);
      end
      m_cnt = n;
      if (f01b) idle = 0;
      else if (idle < TMO) idle++;
      m_sf = ALARM && idle >= TMO;
    end
  end

  always @(negedge clk) begin
    chk("fs", int'(fs), m_cnt);
    chk("fa", int'(fa), int'(m_fa));
    chk("fb", int'(fb), int'(m_fb));
    chk("scafal", int'(scafal), int'(m_sf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    f01b = 1;
    step();
    f01b = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    step();
    step();
    rst = 0;
    chk("reset_fs", int'(fs), 0);
    chk("reset_strobes", int'({fa, fb}), 0);
    chk("reset_scafal", int'(scafal), 0);
    // Three spaced pulses
    pulse();
    chk("p1_fs", int'(fs), 1); chk("p1_fa", int'(fa), 1); chk("p1_fb", int'(fb), 0);
    step();
    chk("p1_width", int'({fa, fb}), 0);
    step(); step();
    pulse();
    chk("p2_fs", int'(fs), 2); chk("p2_fa", int'(fa), 2); chk("p2_fb", int'(fb), 1);
    step();
    chk("p2_width", int'({fa, fb}), 0);
    step(); step();
    pulse();
    chk("p3_fs", int'(fs), 3); chk("p3_fa", int'(fa), 1); chk("p3_fb", int'(fb), 0);
    step();
    chk("p3_width", int'({fa, fb}), 0);
    // Full wrap over 32 pulses
    do_reset();
    fa4_hits = 0; fa4_at = 0;
    for (int p = 1; p <= 32; p++) begin
      pulse();
      if (fa[4]) begin fa4_hits++; fa4_at = p; end
      if (p == 32) begin
        chk("wrap_fs", int'(fs), 0);
        chk("wrap_fb", int'(fb), 31);
        chk("wrap_fa", int'(fa), 0);
      end
      step();
    end
    chk("fa4_hits", fa4_hits, 1);
    chk("fa4_at", fa4_at, 16);
    // Clear wins over a simultaneous increment
    do_reset();
    repeat (5) pulse();
    chk("pre_clr_fs", int'(fs), 5);
    sclclr = 1; f01b = 1;
    step();
    sclclr = 0; f01b = 0;
    chk("clr_fs", int'(fs), 0);
    chk("clr_strobes", int'({fa, fb}), 0);
    pulse();
    chk("post_clr_fs", int'(fs), 1);
    // Back-to-back increments
    do_reset();
    f01b = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("b2b_fs", int'(fs), i);
      chk("b2b_fa0", int'(fa[0]), i % 2);
      chk("b2b_fb0", int'(fb[0]), 1 - i % 2);
    end
    f01b = 0;
    // Asynchronous reset between edges
    do_reset();
    repeat (9) pulse();
    chk("pre_rst_fs", int'(fs), 9);
    #1 rst = 1;
    #1;
    chk("async_rst_fs", int'(fs), 0);
    chk("async_rst_strobes", int'({fa, fb}), 0);
    chk("async_rst_scafal", int'(scafal), 0);
    step();
    rst = 0;
    step(); step();
    chk("post_rst_fs", int'(fs), 0);
    pulse();
    chk("post_rst_pulse_fs", int'(fs), 1);
    // Watchdog alarm
    do_reset();
    repeat (15) step();
    chk("alarm_15", int'(scafal), 0);
    step();
    chk("alarm_16", int'(scafal), int'(ALARM));
    repeat (5) step();
    chk("alarm_hold", int'(scafal), int'(ALARM));
    f01b = 1;
    #2;
    chk("alarm_before_edge", int'(scafal), int'(ALARM));
    step();
    f01b = 0;
    chk("alarm_drop", int'(scafal), 0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
